// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter slice.
package arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arbstate_t;

  // Requester slot assignment.
  localparam int unsigned REQ_DWRITE = 0;
  localparam int unsigned REQ_DREAD  = 1;
  localparam int unsigned REQ_LOADER = 2;

  // Increment an index modulo n.
  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand;

  // Walk NREQ candidates starting at ptr and keep the first requester found.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = ptr_i;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
      cand = IW'(wrap_inc(32'(cand), NREQ));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: round-robin among requesters with optional
// grant locking (read-modify-write) bounded by LOCK_MAX cycles.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned LOCK_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ-1:0][15:0] addr,
  input  logic [NREQ-1:0][15:0] wdata,
  input  logic [NREQ-1:0][1:0]  we,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [15:0]           rdata,
  output logic                  mem_en,
  output logic [15:0]           mem_addr,
  output logic [15:0]           mem_wdata,
  output logic [1:0]            mem_we,
  input  logic [15:0]           mem_rdata,
  output logic                  lock_err
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  arbstate_t       state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic [IW-1:0]   gidx;
  logic            gany;
  logic            at_max;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign at_max = (cnt_q == CW'(LOCK_MAX));

  // State register: arbitration state, pointer, lock owner/counter, read-valid pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Next state: advance pointer on free grants, enter/leave lock, bound lock length.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rvalid_d = '0;
    if (gany && (we[gidx] == 2'b00)) begin
      rvalid_d[gidx] = 1'b1;
    end
    unique case (state_q)
      ARB: begin
        if (gany) begin
          ptr_d = IW'(wrap_inc(32'(gidx), NREQ));
          if (lock[gidx]) begin
            state_d = LOCKED;
            owner_d = gidx;
            cnt_d   = CW'(1);
          end
        end
      end
      LOCKED: begin
        if (at_max) begin
          state_d = ARB;
          ptr_d   = IW'(wrap_inc(32'(owner_q), NREQ));
          cnt_d   = '0;
        end else if (!lock[owner_q]) begin
          state_d = ARB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Outputs: grant selection (gated by reset), RAM mux, read data, lock error pulse.
  always_comb begin
    gnt      = '0;
    gidx     = '0;
    gany     = 1'b0;
    lock_err = 1'b0;
    if (reset) begin
      unique case (state_q)
        ARB: begin
          gnt  = pick_gnt;
          gidx = pick_idx;
          gany = pick_any;
        end
        LOCKED: begin
          lock_err = at_max;
          if (req[owner_q]) begin
            gnt[owner_q] = 1'b1;
            gidx         = owner_q;
            gany         = 1'b1;
          end
        end
        default: ;
      endcase
    end
    mem_en    = gany;
    mem_addr  = gany ? addr[gidx]  : '0;
    mem_wdata = gany ? wdata[gidx] : '0;
    mem_we    = gany ? we[gidx]    : '0;
    rvalid    = rvalid_q;
    rdata     = (|rvalid_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import arb_pkg::*;

  localparam int unsigned NREQ     = 3;
  localparam int unsigned LOCK_MAX = 15;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ-1:0][15:0] addr;
  logic [NREQ-1:0][15:0] wdata;
  logic [NREQ-1:0][1:0]  we;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rvalid;
  logic [15:0]           rdata;
  logic                  mem_en;
  logic [15:0]           mem_addr;
  logic [15:0]           mem_wdata;
  logic [1:0]            mem_we;
  logic [15:0]           mem_rdata;
  logic                  lock_err;

  mem_arbiter #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .lock_err  (lock_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int unsigned i);
    return 16'(16'hA000 + i * 7);
  endfunction

  // RAM model driven by the DUT's memory port; loads itself on the first edge.
  logic [15:0] ram [256];
  logic        ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we == 2'b00) mem_rdata <= ram[mem_addr[8:1]];
      else begin
        if (mem_we[0]) ram[mem_addr[8:1]][7:0]  <= mem_wdata[7:0];
        if (mem_we[1]) ram[mem_addr[8:1]][15:8] <= mem_wdata[15:8];
      end
    end
  end

  typedef struct {
    int unsigned due;
    int unsigned idx;
    logic [15:0] data;
  } rd_t;

  rd_t         sb[$];
  logic [15:0] shadow [256];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference arbiter state.
  logic        m_locked;
  int unsigned m_ptr, m_owner, m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_ptr    = 0;
    m_owner  = 0;
    m_cnt    = 0;
    sb.delete();
  endtask

  task automatic model_comb(output logic [NREQ-1:0] g, output int unsigned gi,
                            output logic ga, output logic err);
    g = '0; gi = 0; ga = 1'b0; err = 1'b0;
    if (reset) begin
      if (!m_locked) begin
        for (int k = 0; k < NREQ; k++) begin
          int unsigned c;
          c = (m_ptr + k) % NREQ;
          if (!ga && req[c]) begin ga = 1'b1; gi = c; end
        end
      end else begin
        err = (m_cnt == LOCK_MAX);
        if (req[m_owner]) begin ga = 1'b1; gi = m_owner; end
      end
      if (ga) g[gi] = 1'b1;
    end
  endtask

  task automatic model_seq(input int unsigned gi, input logic ga);
    if (!reset) model_reset();
    else if (!m_locked) begin
      if (ga) begin
        m_ptr = (gi + 1) % NREQ;
        if (lock[gi]) begin m_locked = 1'b1; m_owner = gi; m_cnt = 1; end
      end
    end else begin
      if (m_cnt == LOCK_MAX) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % NREQ;
      end else if (!lock[m_owner]) m_locked = 1'b0;
      else m_cnt++;
    end
  endtask

  // One clock: check outputs at negedge against hand values and the model, then advance.
  task automatic cycle(input logic [NREQ-1:0] xg, input logic xerr);
    logic [NREQ-1:0] eg;
    int unsigned     gi;
    logic            ga, eerr;
    rd_t             r;
    @(negedge clk);
    model_comb(eg, gi, ga, eerr);
    check_eq("gnt_exp",      32'(gnt),       32'(xg));
    check_eq("lock_err_exp", 32'(lock_err),  32'(xerr));
    check_eq("gnt",          32'(gnt),       32'(eg));
    check_eq("lock_err",     32'(lock_err),  32'(eerr));
    check_eq("mem_en",       32'(mem_en),    32'(ga));
    check_eq("mem_addr",     32'(mem_addr),  ga ? 32'(addr[gi])  : 32'd0);
    check_eq("mem_wdata",    32'(mem_wdata), ga ? 32'(wdata[gi]) : 32'd0);
    check_eq("mem_we",       32'(mem_we),    ga ? 32'(we[gi])    : 32'd0);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      check_eq("rvalid", 32'(rvalid), 32'd1 << r.idx);
      check_eq("rdata",  32'(rdata),  32'(r.data));
    end else begin
      check_eq("rvalid_idle", 32'(rvalid), 32'd0);
      check_eq("rdata_idle",  32'(rdata),  32'd0);
    end
    if (ga) begin
      if (we[gi] == 2'b00) begin
        r.due  = cyc + 1;
        r.idx  = gi;
        r.data = shadow[addr[gi][8:1]];
        sb.push_back(r);
      end else begin
        if (we[gi][0]) shadow[addr[gi][8:1]][7:0]  = wdata[gi][7:0];
        if (we[gi][1]) shadow[addr[gi][8:1]][15:8] = wdata[gi][15:8];
      end
    end
    @(posedge clk);
    model_seq(gi, ga);
    cyc++;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    model_reset();
    reset = 1'b0;
    req   = '0;
    lock  = '0;
    we    = '0;
    addr[0] = 16'h0010; addr[1] = 16'h0022; addr[2] = 16'h0034;
    wdata[0] = 16'h1111; wdata[1] = 16'h2222; wdata[2] = 16'h3333;

    // Reset state: everything quiet even with requests present.
    cycle(3'b000, 1'b0);
    req = 3'b111;
    cycle(3'b000, 1'b0);
    req = '0;
    reset = 1'b1;

    // Round robin over three readers.
    req = 3'b111;
    cycle(3'b001, 1'b0);
    cycle(3'b010, 1'b0);
    cycle(3'b100, 1'b0);
    cycle(3'b001, 1'b0);
    req = '0;
    cycle(3'b000, 1'b0);

    // Single byte write, then read back the merged word.
    req = 3'b001; addr[0] = 16'h4000; wdata[0] = 16'haa55; we[0] = 2'b01;
    cycle(3'b001, 1'b0);
    we[0] = 2'b00;
    cycle(3'b001, 1'b0);
    req = '0;
    cycle(3'b000, 1'b0);

    // Loader lock held five cycles against a pending data read.
    req = 3'b010;
    cycle(3'b010, 1'b0);
    req = 3'b110; lock = 3'b100; addr[2] = 16'h0046;
    for (int k = 0; k < 5; k++) cycle(3'b100, 1'b0);
    req = 3'b010; lock = 3'b000;
    cycle(3'b000, 1'b0);
    cycle(3'b010, 1'b0);
    req = '0;
    cycle(3'b000, 1'b0);

    // Lock held past LOCK_MAX: forced release, one idle locked cycle inside.
    req = 3'b010; lock = 3'b010;
    cycle(3'b010, 1'b0);
    for (int k = 1; k <= int'(LOCK_MAX); k++) begin
      req = (k == 5) ? 3'b001 : 3'b011;
      cycle((k == 5) ? 3'b000 : 3'b010, (k == int'(LOCK_MAX)) ? 1'b1 : 1'b0);
    end
    req = 3'b011;
    cycle(3'b001, 1'b0);
    req = '0; lock = '0;
    cycle(3'b000, 1'b0);

    // Reset right after a granted read discards the pending read data.
    req = 3'b010;
    cycle(3'b010, 1'b0);
    reset = 1'b0;
    model_reset();
    req = 3'b111;
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);
    reset = 1'b1;
    req = 3'b110;
    cycle(3'b010, 1'b0);
    req = '0;
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
